// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared types and constants for the serial core TX/RX paths.
// Revision : 1.0
// ============================================================================
package uart_pkg;

    localparam int TICKS_PER_BIT_DEF = 16;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // Keeps only the low (size + 5) bits of a data word.
    function automatic logic [7:0] data_mask(input logic [1:0] size);
        case (size)
            2'd0:    data_mask = 8'h1F;
            2'd1:    data_mask = 8'h3F;
            2'd2:    data_mask = 8'h7F;
            default: data_mask = 8'hFF;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tick.sv
`default_nettype none
// ============================================================================
// Module   : uart_tick
// Purpose  : Rising-edge detector on the baud strobe, gated by enable.
// Revision : 1.0
// ============================================================================
module uart_tick (
    input  logic clk,
    input  logic reset,
    input  logic brgen_i,
    input  logic enable_i,
    output logic tick_o
);

    logic brgen_old_q;

    // The history register tracks brgen even while disabled so that
    // re-enabling never produces a spurious tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            brgen_old_q <= 1'b0;
        end else begin
            brgen_old_q <= brgen_i;
        end
    end

    assign tick_o = brgen_i && !brgen_old_q && enable_i;

endmodule
`default_nettype wire

// File: rtl/transmitter.sv
`default_nettype none
// ============================================================================
// Module   : transmitter
// Purpose  : UART serialiser: start, 5-8 data bits LSB first, parity, stop.
// Revision : 1.0
// ============================================================================
module transmitter
    import uart_pkg::*;
#(
    parameter int TICKS_PER_BIT = TICKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       brgen,
    input  logic       enable,
    input  logic [1:0] size,
    input  logic       stop2,
    input  logic [1:0] parity,
    input  logic [7:0] data,
    input  logic       data_valid,
    output logic       data_request,
    output logic       out,
    output logic       busy
);

    localparam logic [3:0] LAST_TICK = 4'(TICKS_PER_BIT - 1);

    logic       tick;
    tx_state_t  state_q,   state_d;
    logic [3:0] cnt_q,     cnt_d;
    logic [2:0] idx_q,     idx_d;
    logic [7:0] shift_q,   shift_d;
    logic [2:0] last_q,    last_d;
    logic       stop2_q,   stop2_d;
    logic       par_en_q,  par_en_d;
    logic       par_bit_q, par_bit_d;
    logic       out_q,     out_d;
    logic       req_q,     req_d;

    logic       xfer;
    logic       bit_end;
    logic [7:0] masked;

    uart_tick u_tick (
        .clk      (clk),
        .reset    (reset),
        .brgen_i  (brgen),
        .enable_i (enable),
        .tick_o   (tick)
    );

    assign masked  = data & data_mask(size);
    assign xfer    = data_valid && req_q;
    assign bit_end = tick && (cnt_q == LAST_TICK);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        last_d    = last_q;
        stop2_d   = stop2_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        out_d     = out_q;
        req_d     = req_q;

        if (tick && (state_q != IDLE)) begin
            cnt_d = bit_end ? 4'd0 : cnt_q + 4'd1;
        end

        case (state_q)
            IDLE: begin
                out_d = 1'b1;
                req_d = enable;
                // Frame format is captured here so later control writes
                // only affect the next word.
                if (xfer) begin
                    shift_d   = masked;
                    last_d    = {1'b0, size} + 3'd4;
                    stop2_d   = stop2;
                    par_en_d  = (parity == PAR_EVEN) || (parity == PAR_ODD);
                    par_bit_d = (^masked) ^ (parity == PAR_ODD);
                    cnt_d     = 4'd0;
                    idx_d     = 3'd0;
                    out_d     = 1'b0;
                    req_d     = 1'b0;
                    state_d   = START;
                end
            end

            START: begin
                if (bit_end) begin
                    out_d   = shift_q[0];
                    state_d = DATA;
                end
            end

            DATA: begin
                if (bit_end) begin
                    if (idx_q == last_q) begin
                        idx_d = 3'd0;
                        if (par_en_q) begin
                            out_d   = par_bit_q;
                            state_d = PARITY;
                        end else begin
                            out_d   = 1'b1;
                            state_d = STOP;
                        end
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shift_d = shift_q >> 1;
                        out_d   = shift_q[1];
                    end
                end
            end

            PARITY: begin
                if (bit_end) begin
                    idx_d   = 3'd0;
                    out_d   = 1'b1;
                    state_d = STOP;
                end
            end

            STOP: begin
                if (bit_end) begin
                    if (stop2_q && (idx_q == 3'd0)) begin
                        idx_d = 3'd1;
                    end else begin
                        idx_d   = 3'd0;
                        req_d   = enable;
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                out_d   = 1'b1;
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            idx_q     <= 3'd0;
            shift_q   <= 8'd0;
            last_q    <= 3'd0;
            stop2_q   <= 1'b0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            out_q     <= 1'b1;
            req_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            last_q    <= last_d;
            stop2_q   <= stop2_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            out_q     <= out_d;
            req_q     <= req_d;
        end
    end

    assign data_request = req_q;
    assign out          = out_q;
    assign busy         = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_transmitter
// Purpose  : Self-checking bench for the UART transmitter.
// Revision : 1.0
// ============================================================================
module tb_transmitter;

    localparam int T = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       brgen;
    logic       enable;
    logic [1:0] size;
    logic       stop2;
    logic [1:0] parity;
    logic [7:0] data;
    logic       data_valid;
    logic       data_request;
    logic       out;
    logic       busy;

    always #5 clk = ~clk;

    transmitter #(.TICKS_PER_BIT(T)) dut (
        .clk          (clk),
        .reset        (reset),
        .brgen        (brgen),
        .enable       (enable),
        .size         (size),
        .stop2        (stop2),
        .parity       (parity),
        .data         (data),
        .data_valid   (data_valid),
        .data_request (data_request),
        .out          (out),
        .busy         (busy)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: a frame is a list of line levels, each held T ticks.
    bit m_busy = 1'b0;
    bit m_req  = 1'b0;
    bit m_prev = 1'b0;
    int m_tc   = 0;
    int m_nbits = 0;
    bit m_bits[16];
    int dut_ticks = 0;

    typedef struct {
        logic [7:0] d;
        logic [1:0] sz;
        logic       s2;
        logic [1:0] par;
        int         drop;
        string      pat;
    } vec_t;

    vec_t vecs[6];

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checks_str(input string name, input string act, input string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %s expected %s at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load_frame(input logic [7:0] d, input logic [1:0] sz,
                              input logic s2, input logic [1:0] par);
        int len;
        int ones;
        int n;
        len  = int'(sz) + 5;
        ones = 0;
        n    = 0;
        m_bits[n] = 1'b0;
        n = n + 1;
        for (int i = 0; i < len; i++) begin
            m_bits[n] = d[i];
            ones = ones + int'(d[i]);
            n = n + 1;
        end
        if (par == 2'd1) begin
            m_bits[n] = (ones % 2) == 1;
            n = n + 1;
        end else if (par == 2'd2) begin
            m_bits[n] = (ones % 2) == 0;
            n = n + 1;
        end
        for (int i = 0; i < (s2 ? 2 : 1); i++) begin
            m_bits[n] = 1'b1;
            n = n + 1;
        end
        m_nbits = n;
    endtask

    // One clock: predict from the inputs presented, then compare after the edge.
    task automatic step(input bit rand_brgen);
        bit   tk;
        bit   xfer;
        bit   en_pre;
        bit   rst_pre;
        logic busy_pre;
        rst_pre  = reset;
        en_pre   = enable;
        busy_pre = busy;
        tk   = brgen && !m_prev && enable;
        xfer = rst_pre && !m_busy && m_req && data_valid;
        @(posedge clk);
        #1;
        if (!rst_pre) begin
            m_busy = 1'b0;
            m_req  = 1'b0;
            m_prev = 1'b0;
        end else begin
            m_prev = brgen;
            if (tk && busy_pre === 1'b1) dut_ticks = dut_ticks + 1;
            if (xfer) begin
                load_frame(data, size, stop2, parity);
                m_busy = 1'b1;
                m_tc   = 0;
                m_req  = 1'b0;
            end else if (m_busy) begin
                if (tk) m_tc = m_tc + 1;
                if (m_tc == m_nbits * T) begin
                    m_busy = 1'b0;
                    m_req  = en_pre;
                end
            end else begin
                m_req = en_pre;
            end
        end
        check1("out", out, m_busy ? m_bits[m_tc / T] : 1'b1);
        check1("busy", busy, m_busy);
        check1("data_request", data_request, m_req);
        if (rand_brgen) brgen = 1'($urandom_range(0, 1));
    endtask

    // Follows a frame that has just started and records the level seen per bit.
    task automatic capture(input int drop_tick, input logic [1:0] sz,
                           output string seen, output int ticks);
        logic obs[16];
        int   guard;
        bit   dropped;
        logic lvl;
        guard   = 0;
        dropped = 1'b0;
        while (m_busy && guard < 6000) begin
            obs[m_tc / T] = out;
            if (drop_tick >= 0 && !dropped && m_tc == drop_tick) begin
                dropped = 1'b1;
                lvl     = out;
                enable  = 1'b0;
                repeat (40) step(1'b1);
                check1("hold_level", out, lvl);
                check1("hold_busy", busy, 1'b1);
                size   = ~sz;
                enable = 1'b1;
            end
            step(1'b1);
            guard++;
        end
        if (m_busy) begin
            errors++;
            $display("FAIL frame_timeout: still busy after %0d cycles", guard);
        end
        seen = "";
        for (int k = 0; k < m_nbits; k++) begin
            seen = {seen, (obs[k] === 1'b1) ? "1" : ((obs[k] === 1'b0) ? "0" : "x")};
        end
        ticks = dut_ticks;
    endtask

    task automatic start_word(input logic [7:0] d, input logic [1:0] sz,
                              input logic s2, input logic [1:0] par);
        int guard;
        data       = d;
        size       = sz;
        stop2      = s2;
        parity     = par;
        data_valid = 1'b1;
        guard      = 0;
        while (!m_busy && guard < 200) begin
            step(1'b1);
            guard++;
        end
        data_valid = 1'b0;
        dut_ticks  = 0;
        if (!m_busy) begin
            errors++;
            $display("FAIL start_timeout: no transfer after %0d cycles", guard);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        string seen;
        int    ticks;
        int    gap;
        int    guard;

        vecs[0] = '{8'hA5, 2'd3, 1'b0, 2'd0, -1, "0101001011"};
        vecs[1] = '{8'h35, 2'd2, 1'b1, 2'd1, -1, "01010110011"};
        vecs[2] = '{8'hFF, 2'd0, 1'b0, 2'd2, -1, "01111101"};
        vecs[3] = '{8'h55, 2'd3, 1'b0, 2'd0, 4 * T + 5, "0101010101"};
        vecs[4] = '{8'h3C, 2'd1, 1'b1, 2'd3, -1, "000111111"};
        vecs[5] = '{8'h96, 2'd3, 1'b0, 2'd2, -1, "00110100111"};

        reset      = 1'b0;
        enable     = 1'b1;
        brgen      = 1'b0;
        data_valid = 1'b0;
        data       = 8'h00;
        size       = 2'd0;
        stop2      = 1'b0;
        parity     = 2'd0;

        #12;
        check1("reset_out", out, 1'b1);
        check1("reset_busy", busy, 1'b0);
        check1("reset_req", data_request, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(1'b0);
        check1("req_after_reset", data_request, 1'b1);

        for (int v = 0; v < 6; v++) begin
            start_word(vecs[v].d, vecs[v].sz, vecs[v].s2, vecs[v].par);
            capture(vecs[v].drop, vecs[v].sz, seen, ticks);
            checks_str($sformatf("pattern_%0d", v), seen, vecs[v].pat);
            checki($sformatf("ticks_%0d", v), ticks, vecs[v].pat.len() * T);
            repeat (3) step(1'b1);
        end

        // Back-to-back words with data_valid held high.
        data       = 8'h55;
        size       = 2'd3;
        stop2      = 1'b0;
        parity     = 2'd0;
        data_valid = 1'b1;
        guard      = 0;
        while (!m_busy && guard < 200) begin
            step(1'b1);
            guard++;
        end
        data  = 8'h0F;
        guard = 0;
        while (busy === 1'b1 && guard < 6000) begin
            step(1'b1);
            guard++;
        end
        gap = 0;
        while (busy === 1'b0 && gap < 50) begin
            gap++;
            step(1'b1);
        end
        data_valid = 1'b0;
        dut_ticks  = 0;
        checki("b2b_gap_clks", gap, 1);
        check1("b2b_start_bit", out, 1'b0);
        capture(-1, 2'd3, seen, ticks);
        checks_str("b2b_pattern", seen, "0111100001");
        checki("b2b_ticks", ticks, 10 * T);
        repeat (3) step(1'b1);

        // Reset asserted in the middle of a data bit driving 0.
        start_word(8'hA5, 2'd3, 1'b0, 2'd0);
        guard = 0;
        while (m_tc != 2 * T + 3 && guard < 2000) begin
            step(1'b1);
            guard++;
        end
        check1("pre_reset_out", out, 1'b0);
        reset = 1'b0;
        #2;
        check1("async_reset_out", out, 1'b1);
        check1("async_reset_busy", busy, 1'b0);
        check1("async_reset_req", data_request, 1'b0);
        step(1'b1);
        step(1'b1);
        reset = 1'b1;
        step(1'b1);
        check1("req_after_midreset", data_request, 1'b1);

        // Randomised traffic, all controls churned every cycle.
        for (int c = 0; c < 8000; c++) begin
            enable     = ($urandom_range(0, 15) != 0);
            data_valid = 1'($urandom_range(0, 1));
            data       = 8'($urandom);
            size       = 2'($urandom_range(0, 3));
            stop2      = 1'($urandom_range(0, 1));
            parity     = 2'($urandom_range(0, 3));
            step(1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/transmitter.md
# transmitter

UART serial transmitter: the transmit-side counterpart of the serial core's receiver. It accepts one data word per valid/ready handshake from the transmit FIFO and serialises it onto `out` as start bit, 5–8 data bits LSB first, an optional parity bit and 1 or 2 stop bits. Bit timing comes from the shared baud-rate generator's 16× oversample strobe `brgen`. Frame format is programmed by the same `size`/`stop2`/`parity` control-register fields that drive the receiver.

## Interface
- `TICKS_PER_BIT`, default 16: brgen rising edges per serial bit; must match the receiver's oversample ratio.

- `clk` input 1: system clock; all logic on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `brgen` input 1: baud-rate generator output; each rising edge (sampled in `clk`) is one tick.
- `enable` input 1: transmitter enable; low freezes tick counting and withholds `data_request`.
- `size` input 2: data length = `size` + 5 bits (0→5 … 3→8).
- `stop2` input 1: 0 = one stop bit, 1 = two stop bits.
- `parity` input 2: 0 = none, 1 = even, 2 = odd, 3 = none.
- `data` input 8: word to send; bits above the data length are ignored.
- `data_valid` input 1: `data` is valid (FIFO not empty).
- `data_request` output 1: transmitter ready for a word; transfer occurs on a clk edge where `data_valid` && `data_request`.
- `out` output 1: serial line, idle high.
- `busy` output 1: frame in progress (state ≠ IDLE).

## Operation
- Tick: `tick` = `brgen` && !`brgen_old` && `enable`. `brgen_old` updates every clk, including while `enable` is low.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE
  - `out` = 1.
  - `data_request` = `enable`, registered.
  - On transfer, latch `data`, `size`, `stop2` and `parity` into shadow registers.
  - Clear the tick counter and bit index, then go to START.
  - Control inputs changed mid-frame have no effect until the next transfer.
- START: `out` = 0 for `TICKS_PER_BIT` ticks → DATA.
- DATA
  - `out` = shadow bit[index], index starting at 0, each bit held for `TICKS_PER_BIT` ticks.
  - After bit (length−1): go to PARITY if shadow parity is 1 or 2, else to STOP.
- PARITY: `out` = XOR of the data bits (even), or its inverse (odd), for one bit time → STOP.
- STOP
  - `out` = 1 for 1 or 2 bit times → IDLE.
  - `data_request` reasserts on the clk after the last stop tick.
- Each bit time is counted as ticks 0..TICKS_PER_BIT−1. The last tick of a bit advances to the next bit or state.
- `enable` low mid-frame: the frame pauses, `out` holds its current level, and the counter and state hold. The frame resumes when `enable` returns.
- `data_valid` while `data_request` is low is ignored. The upstream FIFO holds `data` until transfer.

## Timing
- Reset values: `out`=1, `data_request`=0, `busy`=0, state=IDLE, counter=0, index=0, `brgen_old`=0.
- `data_request` is 1 on the first clk after reset deassertion if `enable` is 1.
- Transfer at clk edge N:
  - `data_request`=0, `busy`=1 and `out`=0 are all registered from edge N. The start bit begins immediately, not at the next tick.
  - The start bit lasts until the TICKS_PER_BIT-th tick after N.
- Frame duration in ticks = 16 × (1 + length + parity? 1 : 0 + stop2? 2 : 1). Examples: 8N1 = 160, 7E2 = 176.
- Back-to-back frames:
  - `data_request` rises one clk after the final stop tick.
  - With `data_valid` high, the next start bit begins on that clk, so there is no idle bit between frames.
- Reset asserted mid-frame: `out` goes to 1 asynchronously and the in-flight word is discarded.
- A `brgen` edge and a transfer on the same clk: the tick is not counted toward the new start bit.

## Structure
- Package `uart_pkg`:
  - state enum `tx_state_t` (IDLE, START, DATA, PARITY, STOP);
  - parity constants `PAR_NONE`=0, `PAR_EVEN`=1, `PAR_ODD`=2;
  - `TICKS_PER_BIT_DEF`=16.
  - The receiver reuses the parity constants.
- Sub-module `uart_tick`: brgen rising-edge detector gated by `enable`, producing the one-clk `tick`. It is shared with the receiver.
- Single FSM with a 4-bit tick counter, a 3-bit bit index and an 8-bit shadow shift register.

## Test plan
- 8N1, `data`=0xA5, single transfer → `out` = 0,1,0,1,0,0,1,0,1,1, each bit 16 ticks. `busy` is high for 160 ticks, then `data_request`=1.
- 7E2, `data`=0x35 → start 0; data 1,0,1,0,1,1,0; parity 0; stop 1,1. 176 ticks total.
- 5O1, `data`=0xFF → start 0, data 1,1,1,1,1, parity 0, stop 1. Bits 7:5 are not sent.
- Two words 0x55, 0x0F with `data_valid` held high → the second start bit begins one clk after the first frame's last stop tick, with no idle high bit.
- `enable` dropped for 40 clks during data bit 3 → `out` holds its level, and the remaining ticks resume unchanged afterward. `size` changed mid-frame → the current frame is unaffected.
- `reset` asserted mid-DATA → `out`=1, `busy`=0 and `data_request`=0 immediately. After release with `enable`=1, `data_request`=1 one clk later.
